// File: rtl/frame_plotter_pkg.sv
// Shared constants and encodings for the frame plotter and its rectangle scanner.
package frame_plotter_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    // Game state codes carried on the shared state bus
    localparam logic [2:0] CLEAR_STATE = 3'd0;
    localparam logic [2:0] PLAY_STATE  = 3'd1;
    localparam logic [2:0] OVER_STATE  = 3'd2;

    localparam logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/frame_plotter_rect_scanner.sv
// Row-major walk over a latched rectangle; reports on-screen pixels and the final pixel.
module rect_scanner
    import frame_plotter_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       advance,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [7:0] req_w,
    input  logic [6:0] req_h,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y,
    output logic       pix_valid,
    output logic       last
);

    // One extra bit on both axes so right/bottom edges past the screen never wrap
    logic [8:0] x0;
    logic [8:0] x_end;
    logic [7:0] y_end;
    logic [8:0] cx;
    logic [7:0] cy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x0    <= '0;
            x_end <= '0;
            y_end <= '0;
            cx    <= '0;
            cy    <= '0;
        end else if (start) begin
            x0    <= {1'b0, req_x};
            x_end <= {1'b0, req_x} + {1'b0, req_w} - 9'd1;
            y_end <= {1'b0, req_y} + {1'b0, req_h} - 8'd1;
            cx    <= {1'b0, req_x};
            cy    <= {1'b0, req_y};
        end else if (advance && !last) begin
            if (cx == x_end) begin
                cx <= x0;
                cy <= cy + 8'd1;
            end else begin
                cx <= cx + 9'd1;
            end
        end
    end

    assign last      = (cx == x_end) && (cy == y_end);
    assign pix_valid = (cx < 9'(SCREEN_W)) && (cy < 8'(SCREEN_H));
    assign pix_x     = cx[7:0];
    assign pix_y     = cy[6:0];

endmodule

// File: rtl/frame_plotter.sv
// Single owner of the VGA adapter pixel port: forwards clear-scan plots or fills
// requested rectangles one pixel per clock.
//
// state | meaning
// IDLE  | waiting for a request (ready only outside the clear state)
// FILL  | walking the latched rectangle, one pixel per cycle
// DONE  | pulse rect_done on the next cycle, then back to IDLE
module frame_plotter
    import frame_plotter_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [2:0]          state,
    input  logic [7:0]          scan_x,
    input  logic [6:0]          scan_y,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_x,
    input  logic [6:0]          req_y,
    input  logic [7:0]          req_w,
    input  logic [6:0]          req_h,
    input  logic [COLOUR_W-1:0] req_colour,
    output logic                rect_done,
    output logic                clear_done,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    fill_state_t         fsm;
    fill_state_t         fsm_nxt;
    logic [COLOUR_W-1:0] col_r;
    logic                clear_seen;
    logic                clearing;
    logic                accept;
    logic                zero_size;
    logic                advance;
    logic                last_hit;
    logic                clear_hit;
    logic                pix_valid;
    logic                last;
    logic [7:0]          pix_x;
    logic [6:0]          pix_y;

    assign clearing  = (state == CLEAR_STATE);
    assign req_ready = resetn && (fsm == IDLE) && !clearing;
    assign accept    = req_valid && req_ready;
    assign zero_size = (req_w == 8'd0) || (req_h == 7'd0);
    assign clear_hit = clearing && (scan_y == 7'(SCREEN_H - 1)) && !clear_seen;

    rect_scanner u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .start     (accept),
        .advance   (advance),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_valid (pix_valid),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) fsm <= IDLE;
        else         fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt  = fsm;
        advance  = 1'b0;
        last_hit = 1'b0;
        case (fsm)
            IDLE: if (accept) fsm_nxt = zero_size ? DONE : FILL;
            FILL: begin
                advance  = 1'b1;
                last_hit = last;
                if (last) fsm_nxt = DONE;
            end
            DONE:    fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
        // Entering the clear state abandons any rectangle in flight
        if (clearing) fsm_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            rect_done  <= 1'b0;
            clear_done <= 1'b0;
            clear_seen <= 1'b0;
            col_r      <= '0;
        end else begin
            if (accept) col_r <= req_colour;

            if (clearing) begin
                x      <= scan_x;
                y      <= scan_y;
                colour <= CLEAR_COLOUR;
                plot   <= 1'b1;
            end else if (fsm == FILL) begin
                x      <= pix_x;
                y      <= pix_y;
                colour <= col_r;
                plot   <= pix_valid;
            end else begin
                plot   <= 1'b0;
            end

            rect_done  <= (fsm == DONE) && !clearing;
            clear_done <= clear_hit;

            if (!clearing)     clear_seen <= 1'b0;
            else if (clear_hit) clear_seen <= 1'b1;
        end
    end

    // last_hit is only meaningful inside FILL; kept for readability of the walk
    logic unused_last;
    assign unused_last = last_hit;

endmodule

// File: doc/frame_plotter.md
Name: frame_plotter

Overview:
- Sits directly downstream of the screen-clear coordinate scanner and directly upstream of the VGA adapter.
- In the clear state it forwards scanner coordinates as clear-colour plots and flags completion.
- In every other state it fills rectangles on request (one pixel per clock) for the game logic.
- It is the single owner of the adapter's x/y/colour/plot inputs.

Parameters:
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- CLEAR_STATE, 3'd0, state code meaning "clear screen".
- CLEAR_COLOUR, 3'b000, colour written during clear.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- state  in  3  game state code; same bus that drives the scanner
- scan_x  in  8  scanner x coordinate
- scan_y  in  7  scanner y coordinate
- req_valid  in  1  rectangle request valid
- req_ready  out  1  block can accept a request this cycle
- req_x  in  8  rectangle left edge
- req_y  in  7  rectangle top edge
- req_w  in  8  rectangle width, 0..160
- req_h  in  7  rectangle height, 0..120
- req_colour  in  3  fill colour
- rect_done  out  1  one-cycle pulse after last pixel of an accepted rectangle
- clear_done  out  1  one-cycle pulse when the clear scan reaches the last row
- x  out  8  pixel x to VGA adapter
- y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour to VGA adapter
- plot  out  1  write enable to VGA adapter

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn.
- Reset values: all outputs 0 (x, y, colour, plot, req_ready, rect_done, clear_done); FSM = IDLE; clear_seen = 0.
- Output timing: x, y, colour and plot are registered, so one-cycle latency from the internal pixel choice.
- Clear path (state == CLEAR_STATE), one cycle later:
  - x = scan_x, y = scan_y, colour = CLEAR_COLOUR, plot = 1.
  - The rectangle FSM is held in IDLE and req_ready = 0.
- clear_done:
  - Pulses one cycle, same cycle as the plot of the first pixel with scan_y == SCREEN_H-1.
  - Fires at most once per clear phase; clear_seen rearms when state leaves CLEAR_STATE.
- Rectangle FSM states: IDLE, FILL, DONE.
- IDLE:
  - req_ready = 1 iff state != CLEAR_STATE.
  - Handshake when req_valid && req_ready: latch all req_* fields and set cx = req_x, cy = req_y.
  - If req_w == 0 or req_h == 0, go to DONE with no plots; otherwise go to FILL.
  - plot = 0 in IDLE.
- FILL, each cycle:
  - Emit (cx, cy, colour) with plot = 1 only if cx < SCREEN_W and cy < SCREEN_H. Off-screen pixels are clipped (plot = 0) but still take their cycle.
  - Scan is row-major: cx increments until cx == x0+w-1, then cx = x0 and cy increments.
  - After pixel (x0+w-1, y0+h-1), go to DONE.
  - Total FILL cycles = w*h.
- Arithmetic: end coordinates use 9-bit (x) and 8-bit (y) sums so x0+w cannot wrap. Counters never wrap past the rectangle.
- DONE: rect_done = 1 for exactly one cycle, plot = 0, then IDLE. req_ready stays 0 in FILL and DONE.
- Pixel-to-pulse timing: the first pixel of a rectangle appears on the outputs 2 cycles after the handshake cycle. rect_done asserts in the cycle after the last pixel appears.
- Abort: if state becomes CLEAR_STATE during FILL or DONE, the FSM goes to IDLE next cycle. No rect_done is pulsed, and the clear path owns the outputs from that cycle on.
- Mid-operation reset: resetn low for one cycle returns everything to reset values. A latched request is discarded.
- Simultaneous events: req_valid in the same cycle that state enters CLEAR_STATE is not accepted (req_ready is already 0).

Decomposition:
- Shared package holds the screen constants (160, 120), CLEAR_STATE and the other game state codes, the colour width, and the FSM state encoding (IDLE=0, FILL=1, DONE=2).
- One sub-module is natural: rect_scanner. It owns the cx/cy counters, the end-of-rectangle compare and the clipping, and exposes start, pixel valid, last and coordinates.

Test Plan:
- Reset then a clear scan: hold state = 0 and drive scan (5,3) → next cycle x=5, y=3, colour=000, plot=1. Scan y=119 → one clear_done pulse only, even if y=119 is held.
- Basic fill: state = 1, request (10,20,3,2,colour 3'b101) → 6 plots in row-major order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), then rect_done one cycle later; req_ready = 0 throughout.
- Zero size: request w=0, h=5 → no plot; rect_done 2 cycles after the handshake; req_ready returns to 1.
- Clipping: request (158,119,4,2) → 8 FILL cycles, plot = 1 only for (158,119) and (159,119).
- Abort: state = 1, request 20×20, state driven to 0 after 50 pixels → no rect_done; outputs follow the scanner with colour 000 from the next cycle.
- Reset mid-fill: resetn low one cycle during FILL → all outputs 0 and FSM IDLE; a new request is then accepted normally.
